// File: rtl/fwd_hazard_scoreboard.sv
// rtl/fwd_hazard_scoreboard.sv - EX..WB forwarding/load-use hazard scoreboard (optional FWD_STALL_CNT_EN stall counter)
module fwd_hazard_scoreboard #(
  parameter int REG_AW   = 5,
  parameter int NUM_SRC  = 2,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                id_valid,
  input  logic [NUM_SRC*REG_AW-1:0]           id_src,
  input  logic [NUM_SRC-1:0]                  id_src_used,
  input  logic [REG_AW-1:0]                   id_rd,
  input  logic                                id_regwrite,
  input  logic                                id_is_load,
  input  logic                                flush_ex,
  output logic                                stall,
  output logic                                ex_valid,
  output logic [NUM_SRC*$clog2(DEPTH)-1:0]    fwd_sel,
  output logic [15:0]                         stall_cnt
);

  localparam int SELW = $clog2(DEPTH);

  // The oldest (WB) entry is never forwarded from, so only e[0..DEPTH-2] are held;
  // the load flag is only consulted while the load is still inside the latency window.
  logic [DEPTH-2:0]  e_vld;
  logic [REG_AW-1:0] e_rd [DEPTH-1];
  logic [LOAD_LAT-1:0] e_ld;

  logic                      load_hit;
  logic                      bubble;
  logic [NUM_SRC*SELW-1:0]   sel_nxt;

  always_comb begin
    load_hit = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      for (int i = 0; i < LOAD_LAT; i++) begin
        if (id_src_used[s] && (id_src[s*REG_AW +: REG_AW] != '0) &&
            e_vld[i] && e_ld[i] && (e_rd[i] == id_src[s*REG_AW +: REG_AW]))
          load_hit = 1'b1;
      end
    end
  end

  assign stall  = id_valid & ~flush_ex & load_hit;
  assign bubble = stall | flush_ex;

  // Scan oldest to youngest so the nearest producer overwrites any older match.
  always_comb begin
    sel_nxt = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (!bubble && id_src_used[s] && (id_src[s*REG_AW +: REG_AW] != '0)) begin
        for (int k = DEPTH - 1; k >= 1; k--) begin
          if (e_vld[k-1] && (e_rd[k-1] == id_src[s*REG_AW +: REG_AW]))
            sel_nxt[s*SELW +: SELW] = SELW'(k);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_vld    <= '0;
      e_ld     <= '0;
      for (int i = 0; i < DEPTH - 1; i++) e_rd[i] <= '0;
      ex_valid <= 1'b0;
      fwd_sel  <= '0;
    end else begin
      for (int i = 1; i < DEPTH - 1; i++) begin
        e_vld[i] <= e_vld[i-1];
        e_rd[i]  <= e_rd[i-1];
      end
      for (int i = 1; i < LOAD_LAT; i++) e_ld[i] <= e_ld[i-1];
      e_vld[0] <= ~bubble & id_valid & id_regwrite & (id_rd != '0);
      e_rd[0]  <= bubble ? '0 : id_rd;
      e_ld[0]  <= ~bubble & id_is_load;
      ex_valid <= id_valid & ~bubble;
      fwd_sel  <= sel_nxt;
    end
  end

`ifdef FWD_STALL_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= 16'h0000;
    else if (stall && (cnt_q != 16'hFFFF))
      cnt_q <= cnt_q + 16'd1;
  end

  assign stall_cnt = cnt_q;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// tb/tb_fwd_hazard_scoreboard.sv - directed and random bench for fwd_hazard_scoreboard against an issue-history model
module tb_fwd_hazard_scoreboard;
  localparam int AW = 5, NS = 2, D = 3, LL = 1, SW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          id_valid = 1'b0;
  logic [NS*AW-1:0] id_src = '0;
  logic [NS-1:0] id_src_used = '0;
  logic [AW-1:0] id_rd = '0;
  logic          id_regwrite = 1'b0;
  logic          id_is_load = 1'b0;
  logic          flush_ex = 1'b0;
  logic          stall;
  logic          ex_valid;
  logic [NS*SW-1:0] fwd_sel;
  logic [15:0]   stall_cnt;

  always #5 clk = ~clk;

  fwd_hazard_scoreboard #(.REG_AW(AW), .NUM_SRC(NS), .DEPTH(D), .LOAD_LAT(LL)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src(id_src), .id_src_used(id_src_used),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_is_load(id_is_load), .flush_ex(flush_ex),
    .stall(stall), .ex_valid(ex_valid), .fwd_sel(fwd_sel), .stall_cnt(stall_cnt)
  );

  // hist[a] = instruction that entered EX a cycles ago (a=0 is the one now in EX)
  typedef struct {bit w; bit [AW-1:0] rd; bit ld;} ins_t;
  ins_t hist[$];
  int   passed = 0, total = 0;
  int   m_cnt = 0;
  logic last_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic bit [AW-1:0] src_of(int s);
    return id_src[s*AW +: AW];
  endfunction

  function automatic bit m_stall();
    bit r = 0;
    for (int s = 0; s < NS; s++)
      for (int a = 0; a < LL && a < hist.size(); a++)
        if (id_src_used[s] && src_of(s) != 0 && hist[a].w && hist[a].ld && hist[a].rd == src_of(s))
          r = 1;
    return id_valid && !flush_ex && r;
  endfunction

  function automatic logic [NS*SW-1:0] m_sel();
    logic [NS*SW-1:0] r = '0;
    for (int s = 0; s < NS; s++) begin
      int age = -1;
      if (!m_stall() && !flush_ex && id_src_used[s] && src_of(s) != 0)
        for (int a = 0; a <= D - 2 && a < hist.size(); a++)
          if (age < 0 && hist[a].w && hist[a].rd == src_of(s)) age = a;
      if (age >= 0) r[s*SW +: SW] = SW'(age + 1);
    end
    return r;
  endfunction

  function automatic int m_cnt_exp();
`ifdef FWD_STALL_CNT_EN
    return m_cnt;
`else
    return 0;
`endif
  endfunction

  task automatic set_id(input bit v, input int s0, input int s1, input bit [1:0] used,
                        input int rd, input bit rw, input bit ld, input bit fl);
    @(negedge clk);
    id_valid = v; id_src = {AW'(s1), AW'(s0)}; id_src_used = used;
    id_rd = AW'(rd); id_regwrite = rw; id_is_load = ld; flush_ex = fl;
  endtask

  task automatic step();
    bit st; bit ev; logic [NS*SW-1:0] sel; ins_t n;
    #1;
    st = m_stall(); ev = id_valid && !st && !flush_ex; sel = m_sel();
    last_stall = stall;
    chk("stall", 32'(stall), 32'(st));
    n.w  = ev && id_regwrite && id_rd != 0;
    n.rd = id_rd; n.ld = id_is_load;
    @(posedge clk);
    if (!(st || flush_ex)) hist.push_front(n);
    else begin ins_t b; b.w = 0; b.rd = 0; b.ld = 0; hist.push_front(b); end
    if (hist.size() > D) void'(hist.pop_back());
    if (st && m_cnt < 65535) m_cnt++;
    #1;
    chk("ex_valid", 32'(ex_valid), 32'(ev));
    chk("fwd_sel", 32'(fwd_sel), 32'(sel));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt_exp()));
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) begin set_id(0, 0, 0, 2'b00, 0, 0, 0, 0); step(); end
  endtask

  initial begin
    int cnt0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ex_valid", 32'(ex_valid), 0);
    chk("rst_fwd_sel", 32'(fwd_sel), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_stall_cnt", 32'(stall_cnt), 0);
    @(negedge clk) rst_n = 1'b1;

    // ALU chain
    set_id(1, 1, 2, 2'b11, 3, 1, 0, 0); step();
    set_id(1, 3, 3, 2'b11, 4, 1, 0, 0); step();
    chk("alu_chain_sel", 32'(fwd_sel), 32'h5);
    nops(3);

    // distance 2
    set_id(1, 1, 1, 2'b11, 5, 1, 0, 0); step();
    nops(1);
    set_id(1, 5, 2, 2'b11, 6, 1, 0, 0); step();
    chk("dist2_sel", 32'(fwd_sel), 32'h2);
    nops(3);

    // load-use: one stall cycle, bubble, then forward from MEM
    cnt0 = int'(stall_cnt);
    set_id(1, 29, 0, 2'b01, 8, 1, 1, 0); step();
    set_id(1, 8, 1, 2'b11, 9, 1, 0, 0); step();
    chk("lu_stall", 32'(last_stall), 1);
    chk("lu_bubble", 32'(ex_valid), 0);
    step();
    chk("lu_stall_after", 32'(last_stall), 0);
    chk("lu_ex_valid", 32'(ex_valid), 1);
    chk("lu_sel", 32'(fwd_sel), 32'h2);
`ifdef FWD_STALL_CNT_EN
    chk("lu_cnt", 32'(stall_cnt), 32'(cnt0 + 1));
`else
    chk("lu_cnt", 32'(stall_cnt), 0);
`endif
    nops(3);

    // $0 producer and unused sources
    set_id(1, 1, 2, 2'b11, 0, 1, 0, 0); step();
    set_id(1, 0, 0, 2'b11, 1, 1, 0, 0); step();
    chk("zero_sel", 32'(fwd_sel), 0);
    set_id(1, 29, 0, 2'b01, 7, 1, 1, 0); step();
    set_id(1, 7, 7, 2'b00, 9, 1, 0, 0); step();
    chk("unused_stall", 32'(last_stall), 0);
    chk("unused_sel", 32'(fwd_sel), 0);
    nops(3);

    // youngest producer wins; flush beats stall
    set_id(1, 1, 1, 2'b11, 2, 1, 0, 0); step();
    set_id(1, 1, 1, 2'b11, 2, 1, 0, 0); step();
    set_id(1, 2, 2, 2'b11, 3, 1, 0, 0); step();
    chk("youngest_sel", 32'(fwd_sel), 32'h5);
    set_id(1, 29, 0, 2'b01, 4, 1, 1, 0); step();
    set_id(1, 4, 4, 2'b11, 5, 1, 0, 1); step();
    chk("flush_stall", 32'(last_stall), 0);
    chk("flush_ex_valid", 32'(ex_valid), 0);
    chk("flush_sel", 32'(fwd_sel), 0);
    nops(3);

    // async reset mid-stall
    set_id(1, 1, 1, 2'b11, 11, 1, 0, 0); step();
    set_id(1, 11, 0, 2'b01, 10, 1, 1, 0); step();
    chk("pre_rst_sel", 32'(fwd_sel), 32'h1);
    set_id(1, 10, 10, 2'b11, 12, 1, 0, 0);
    #1 chk("pre_rst_stall", 32'(stall), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_stall", 32'(stall), 0);
    chk("async_rst_ex_valid", 32'(ex_valid), 0);
    chk("async_rst_sel", 32'(fwd_sel), 0);
    chk("async_rst_cnt", 32'(stall_cnt), 0);
    hist.delete(); m_cnt = 0;
    @(negedge clk) rst_n = 1'b1;
    nops(1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      set_id($urandom_range(0, 9) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
             2'($urandom_range(0, 3)), $urandom_range(0, 7), $urandom_range(0, 3) != 0,
             $urandom_range(0, 2) == 0, $urandom_range(0, 11) == 0);
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
